// File: rtl/shift_pkg.sv
// Shared types and constants for the multi-cycle shift sequencer.
package shift_pkg;

  localparam int unsigned N       = 32;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned STAGE_W = 3;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_SRA = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/shift_stage.sv
// One logarithmic shifter stage: shifts by 2**stage when enabled.
module shift_stage
  import shift_pkg::*;
(
  input  logic [N-1:0]       in,
  input  logic [STAGE_W-1:0] stage,
  input  logic               enable,
  input  shift_op_t          op,
  output logic [N-1:0]       out
);

  logic [SHAMT_W-1:0] amt;

  // Select the stage distance and apply the requested shift kind.
  always_comb begin
    amt = SHAMT_W'(1) << stage;
    out = in;
    if (enable) begin
      case (op)
        SHIFT_SRL: out = in >> amt;
        SHIFT_SRA: out = $unsigned($signed(in) >>> amt);
        default:   out = in << amt;
      endcase
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: accept, five conditional shift stages (16..1), hold result.
module shift_sequencer
  import shift_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [N-1:0] shamt,
  input  logic [1:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         busy
);

  seq_state_t         state_q;
  logic [STAGE_W-1:0] stage_idx_q;
  logic [N-1:0]       acc_q;
  logic [SHAMT_W-1:0] sh_q;
  shift_op_t          op_q;
  logic               out_valid_q;
  logic               busy_q;
  logic [N-1:0]       acc_d;
  logic               unused_shamt_hi;

  // Upper shift-amount bits carry no meaning for a 32-bit datapath.
  assign unused_shamt_hi = ^shamt[N-1:SHAMT_W];

  // Single shared stage, steered by the current stage index.
  shift_stage u_stage (
    .in     (acc_q),
    .stage  (stage_idx_q),
    .enable (sh_q[stage_idx_q]),
    .op     (op_q),
    .out    (acc_d)
  );

  // Requests are taken only in IDLE and never while reset is asserted.
  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign out_data  = acc_q;
  assign busy      = busy_q;

  // Sequencer FSM, stage counter, accumulator and handshake flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      stage_idx_q <= STAGE_W'(4);
      acc_q       <= '0;
      sh_q        <= '0;
      op_q        <= SHIFT_SLL;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            acc_q       <= in_data;
            sh_q        <= shamt[SHAMT_W-1:0];
            // The reserved encoding 2'b10 is folded onto a left shift here.
            op_q        <= (op == 2'b10) ? SHIFT_SLL : shift_op_t'(op);
            stage_idx_q <= STAGE_W'(4);
            state_q     <= S_BUSY;
            busy_q      <= 1'b1;
          end
        end
        S_BUSY: begin
          acc_q <= acc_d;
          if (stage_idx_q == '0) begin
            stage_idx_q <= STAGE_W'(4);
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
          end else begin
            stage_idx_q <= stage_idx_q - STAGE_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer with a cycle-level behavioural model.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [31:0] shamt = '0;
  logic [1:0]  op = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // Model: remaining shift cycles, result held flag and value, op counters.
  int          m_cnt = 0;
  bit          m_valid = 1'b0;
  logic [31:0] m_data = '0;
  logic [31:0] m_res = '0;
  int          accepted = 0;
  int          retired = 0;

  always #5 clk = ~clk;

  shift_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .shamt     (shamt),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [31:0] s,
                                            input logic [1:0] o);
    logic [4:0] a;
    a = s[4:0];
    case (o)
      2'b01:   return d >> a;
      2'b11:   return $unsigned($signed(d) >>> a);
      default: return d << a;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance one clock, step the model with the inputs held across that edge, compare.
  task automatic tick();
    @(negedge clk);
    if (rst) begin
      m_cnt = 0; m_valid = 1'b0; m_data = '0;
    end else if (m_valid) begin
      if (out_ready) begin m_valid = 1'b0; retired++; end
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin m_valid = 1'b1; m_data = m_res; end
    end else if (in_valid) begin
      m_cnt = 5;
      m_res = ref_shift(in_data, shamt, op);
      accepted++;
    end
    chk("in_ready", 32'(in_ready), 32'(!rst && m_cnt == 0 && !m_valid));
    chk("busy", 32'(busy), 32'(m_cnt > 0 || m_valid));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) chk("out_data", out_data, m_data);
  endtask

  // Issue one request from IDLE, check latency and literal result, then retire.
  task automatic do_op(input string nm, input logic [31:0] d, input logic [31:0] s,
                       input logic [1:0] o, input logic [31:0] exp, input int hold);
    int lat;
    in_valid = 1'b1; in_data = d; shamt = s; op = o; out_ready = 1'b0;
    tick();
    chk({nm, "_ready_drop"}, 32'(in_ready), 32'd0);
    in_valid = 1'b0; in_data = $urandom; shamt = $urandom; op = 2'($urandom);
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'd6);
    chk({nm, "_result"}, out_data, exp);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'(i % 2); in_data = $urandom; shamt = $urandom; op = 2'($urandom);
      tick();
      chk({nm, "_hold_data"}, out_data, exp);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk({nm, "_retired"}, 32'(out_valid), 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    int cyc;
    int target;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("reset_out_data", out_data, 32'h0);
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    tick();

    // Directed cases with literal expectations
    do_op("sll31",    32'h0000_0001, 32'd31,         2'b00, 32'h8000_0000, 0);
    do_op("sra4",     32'h8000_00F0, 32'd4,          2'b11, 32'hF800_000F, 0);
    do_op("srl4",     32'h8000_00F0, 32'd4,          2'b01, 32'h0800_000F, 0);
    do_op("bp_hold",  32'h1234_5678, 32'd8,          2'b00, 32'h3456_7800, 10);
    do_op("shamt0",   32'hDEAD_BEEF, 32'd0,          2'b11, 32'hDEAD_BEEF, 0);
    do_op("shamt_hi", 32'h0000_0001, 32'hFFFF_FFE3,  2'b00, 32'h0000_0008, 0);
    do_op("op_rsvd",  32'h0000_0001, 32'd4,          2'b10, 32'h0000_0010, 0);

    // Reset in the middle of an operation (during stage 2)
    in_valid = 1'b1; in_data = 32'hFFFF_0000; shamt = 32'd31; op = 2'b01;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_data", out_data, 32'h0);
    rst = 1'b0;
    tick();
    do_op("after_rst", 32'hF000_0000, 32'd28, 2'b11, 32'hFFFF_FFFF, 2);

    // Randomized traffic against the model
    target = retired + 1000;
    cyc = 0;
    while (retired < target && cyc < 40000) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      shamt     = $urandom;
      op        = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      cyc++;
    end
    chk("random_retired", 32'(retired), 32'(target));
    chk("one_result_per_req", 32'(accepted - retired <= 1), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
